// File: rtl/armleocpu_unsigned_multiplier_pkg.sv
// Shared definitions for the 32x32->64 sequential unsigned multiplier.
// Build option: ARMLEOCPU_MULTIPLIER_RADIX4_EN selects two multiplier bits per cycle.
package armleocpu_defines;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_CALC = 1'b1
  } state_t;

`ifdef ARMLEOCPU_MULTIPLIER_RADIX4_EN
  localparam int unsigned STEP = 2;
`else
  localparam int unsigned STEP = 1;
`endif

  localparam int unsigned ITERATIONS = 32 / STEP;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERATIONS - 1);

  // Counter runs down from CNT_LAST, so the bit position consumed is derived from how far it has run.
  function automatic logic [5:0] bit_index(input logic [CNT_W-1:0] cnt);
    return 6'(32'(CNT_LAST - cnt) * STEP);
  endfunction

endpackage

// File: rtl/armleocpu_unsigned_multiplier_step.sv
// One partial-product accumulation: acc + (factor0 * bits) << bit_idx.
// STEP-wide slice of the multiplier (0..1x or 0..3x factor0 per cycle).
module armleocpu_multiplier_step
  import armleocpu_defines::*;
(
  input  logic [63:0]     acc_i,
  input  logic [31:0]     factor0_i,
  input  logic [STEP-1:0] bits_i,
  input  logic [5:0]      bit_idx_i,
  output logic [63:0]     acc_o
);

  logic [63:0] pp;

  always_comb begin
    pp    = ({32'b0, factor0_i} * 64'(bits_i)) << bit_idx_i;
    acc_o = acc_i + pp;
  end

endmodule

// File: rtl/armleocpu_unsigned_multiplier.sv
// Sequential 32x32->64 unsigned shift-add multiplier, constant latency.
// Build option: ARMLEOCPU_MULTIPLIER_RADIX4_EN halves the CALC phase (16 cycles instead of 32).
module armleocpu_unsigned_multiplier
  import armleocpu_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] factor0,
  input  logic [31:0] factor1,
  output logic        ready,
  output logic [63:0] result
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      f0_q, f0_d;
  logic [31:0]      mul_q, mul_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      result_q, result_d;
  logic             ready_q, ready_d;
  logic [63:0]      acc_next;
  logic [5:0]       bit_idx;

  assign bit_idx = bit_index(cnt_q);

  armleocpu_multiplier_step u_step (
    .acc_i     (acc_q),
    .factor0_i (f0_q),
    .bits_i    (mul_q[STEP-1:0]),
    .bit_idx_i (bit_idx),
    .acc_o     (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f0_d     = f0_q;
    mul_d    = mul_q;
    acc_d    = acc_q;
    result_d = result_q;
    ready_d  = 1'b0;
    unique case (state_q)
      STATE_IDLE: begin
        if (valid) begin
          f0_d    = factor0;
          mul_d   = factor1;
          acc_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = STATE_CALC;
        end
      end
      STATE_CALC: begin
        acc_d = acc_next;
        mul_d = mul_q >> STEP;
        // The last step's sum goes straight to result so ready lands on the final CALC edge.
        if (cnt_q == '0) begin
          state_d  = STATE_IDLE;
          ready_d  = 1'b1;
          result_d = acc_next;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= STATE_IDLE;
      cnt_q    <= '0;
      f0_q     <= '0;
      mul_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f0_q     <= f0_d;
      mul_q    <= mul_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign result = result_q;

endmodule

// File: tb/tb_armleocpu_unsigned_multiplier.sv
// Scoreboard bench for armleocpu_unsigned_multiplier: model predicts accept edges and products.
module tb_armleocpu_unsigned_multiplier;

`ifdef ARMLEOCPU_MULTIPLIER_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] factor0 = '0;
  logic [31:0] factor1 = '0;
  logic        ready;
  logic [63:0] result;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          next_free = 0;
  logic [63:0] held = '0;
  exp_t        q[$];

  armleocpu_unsigned_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .factor0 (factor0),
    .factor1 (factor1),
    .ready   (ready),
    .result  (result)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One clock of stimulus; the model decides acceptance from the request timing alone.
  task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
    int e;
    @(negedge clk);
    rst = r; valid = v; factor0 = a; factor1 = b;
    e = cyc + 1;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      held = '0;
      next_free = 0;
    end else if (v && e >= next_free) begin
      q.push_back('{res: 64'(a) * 64'(b), due: e + LAT});
      next_free = e + LAT + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'(1) << $urandom_range(0, 31);
      2: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor
  initial begin
    logic exp_ready;
    exp_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        exp_ready = (q.size() > 0) && (q[0].due == cyc);
        total++;
        if (ready !== exp_ready) begin
          bad++;
          $display("FAIL ready cyc=%0d got=%b expected=%b", cyc, ready, exp_ready);
        end
        if (exp_ready) begin
          e = q.pop_front();
          held = e.res;
        end
        total++;
        if (result !== held) begin
          bad++;
          $display("FAIL result cyc=%0d got=%h expected=%h", cyc, result, held);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 32'd5, 32'd6);
    drive(1'b1, 1'b0, '0, '0);
    total++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      bad++;
      $display("FAIL reset_state ready=%b result=%h expected 0/0", ready, result);
    end

    // 64x53, then valid held with 10x10 across the ready cycle.
    drive(1'b0, 1'b1, 32'd64, 32'd53);
    idle(LAT - 3);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'd10, 32'd10);
    idle(LAT + 5);

    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(LAT + 3);
    drive(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);         idle(LAT + 3);
    drive(1'b0, 1'b1, 32'h1, 32'h8000_0000);         idle(LAT + 3);

    // 3x5 pulsed mid-calculation must be dropped.
    drive(1'b0, 1'b1, 32'd7, 32'd9);
    idle(5);
    drive(1'b0, 1'b1, 32'd3, 32'd5);
    idle(LAT + 5);

    // Reset at CALC cycle 10 aborts, then 2x3 on the first edge after reset.
    drive(1'b0, 1'b1, 32'd7, 32'd9);
    idle(9);
    drive(1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b1, 32'd2, 32'd3);
    idle(LAT + 3);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) drive(1'b1, 1'($urandom_range(0, 1)), rnd_op(), rnd_op());
      else drive(1'b0, 1'($urandom_range(0, 7) == 0), rnd_op(), rnd_op());
    end

    valid = 1'b0;
    for (int i = 0; i < LAT + 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
